// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_reg
// Brief   : EX/MEM pipeline register with flag register, BRFL redirect pulse
//           and sticky divide-by-zero exception.
// Revision: 1.0
// ============================================================================
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        alu_flag,
    input  logic              alu_branch,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              flag_write,
    input  logic              is_brfl,
    input  logic              exc_ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_wr_addr,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg,
    output logic [2:0]        flag_q,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_pc,
    output logic              exc_pending
);

    localparam logic [2:0] c_FLAG_DIV0 = 3'b010;

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_AW-1:0] r_wr_addr;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic [2:0]        r_flag;
    logic              r_branch_taken;
    logic [DATA_W-1:0] r_branch_pc;
    logic              r_exc_pending;

    logic w_cap;
    logic w_div0;
    logic w_br_taken;
    logic w_kill_writes;

    assign w_cap         = in_valid & ~flush & ~stall & ~r_exc_pending;
    assign w_div0        = (alu_flag == c_FLAG_DIV0);
    assign w_br_taken    = w_cap & is_brfl & ~alu_branch;
    // Faulting instructions and BRFLs travel down the pipe but must not commit.
    assign w_kill_writes = w_div0 | is_brfl;

    // Pipeline payload: data holds on bubbles, control is zeroed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_store_data <= '0;
            r_wr_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            if (w_cap) begin
                r_valid      <= 1'b1;
                r_result     <= alu_result;
                r_store_data <= store_data;
                r_wr_addr    <= wr_addr;
                r_reg_write  <= reg_write & ~w_kill_writes;
                r_mem_read   <= mem_read;
                r_mem_write  <= mem_write & ~w_kill_writes;
                r_mem_to_reg <= mem_to_reg;
            end else begin
                r_valid      <= 1'b0;
                r_reg_write  <= 1'b0;
                r_mem_read   <= 1'b0;
                r_mem_write  <= 1'b0;
                r_mem_to_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_flag <= 3'b000;
        end else if (w_cap && flag_write && !is_brfl) begin
            r_flag <= alu_flag;
        end
    end

    // A stalled edge drops the pulse so a held BRFL never redirects twice.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_branch_taken <= 1'b0;
            r_branch_pc    <= '0;
        end else begin
            r_branch_taken <= w_br_taken;
            if (w_br_taken) begin
                r_branch_pc <= branch_target;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_exc_pending <= 1'b0;
        end else if (w_cap && w_div0) begin
            r_exc_pending <= 1'b1;
        end else if (exc_ack) begin
            r_exc_pending <= 1'b0;
        end
    end

    assign out_valid      = r_valid;
    assign out_result     = r_result;
    assign out_store_data = r_store_data;
    assign out_wr_addr    = r_wr_addr;
    assign out_reg_write  = r_reg_write;
    assign out_mem_read   = r_mem_read;
    assign out_mem_write  = r_mem_write;
    assign out_mem_to_reg = r_mem_to_reg;
    assign flag_q         = r_flag;
    assign branch_taken   = r_branch_taken;
    assign branch_pc      = r_branch_pc;
    assign exc_pending    = r_exc_pending;

endmodule
`default_nettype wire
